// File: rtl/collision_pkg.sv
// Shared types and helpers for player_collision_detector and its priority encoder.
package collision_pkg;

  typedef enum logic [1:0] {ARMED_ST, WAIT_REC_ST, HOLDOFF_ST} state_e;

  localparam int unsigned HIT_BORDER = 0;

  function automatic int unsigned id_width(input int unsigned num_obst);
    return (num_obst < 2) ? 1 : $clog2(num_obst + 1);
  endfunction

endpackage

// File: rtl/hit_priority_enc.sv
// Lowest-index obstacle encoder: obstacle k -> id k+1; no obstacle (border case) -> HIT_BORDER.
module hit_priority_enc
  import collision_pkg::*;
#(
  parameter int unsigned NUM_OBST = 4,
  parameter int unsigned IDW      = 3
) (
  input  logic [NUM_OBST-1:0] obstacle_dr,
  output logic [IDW-1:0]      hit_id
);

  always_comb begin
    hit_id = IDW'(HIT_BORDER);
    // Scan downwards so the lowest active index is the last assignment.
    for (int i = int'(NUM_OBST) - 1; i >= 0; i--) begin
      if (obstacle_dr[i]) hit_id = IDW'(i + 1);
    end
  end

endmodule

// File: rtl/player_collision_detector.sv
// Per-frame player collision detector with recovery wait and hold-off.
// Optional COLLISION_HIT_COUNT_EN adds a saturating hit_count output.
module player_collision_detector
  import collision_pkg::*;
#(
  parameter int unsigned NUM_OBST       = 4,
  parameter int unsigned HOLDOFF_FRAMES = 2,
  localparam int unsigned IDW           = id_width(NUM_OBST)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                player_dr,
  input  logic [NUM_OBST-1:0] obstacle_dr,
  input  logic                border_dr,
  input  logic                totalCollision,
  output logic                collision,
  output logic [IDW-1:0]      hit_id,
  output logic                hit_valid
`ifdef COLLISION_HIT_COUNT_EN
  ,
  output logic [7:0]          hit_count
`endif
);

  logic           pixel_hit;
  logic [IDW-1:0] cause_id;

  state_e         state_q, state_d;
  logic           frame_hit_q, frame_hit_d;
  logic [IDW-1:0] pend_id_q, pend_id_d;
  logic [3:0]     holdoff_cnt_q, holdoff_cnt_d;
  logic           collision_q, collision_d;
  logic [IDW-1:0] hit_id_q, hit_id_d;
  logic           hit_valid_q, hit_valid_d;

  assign pixel_hit = player_dr & ((|obstacle_dr) | border_dr);

  hit_priority_enc #(
    .NUM_OBST (NUM_OBST),
    .IDW      (IDW)
  ) u_hit_priority_enc (
    .obstacle_dr (obstacle_dr),
    .hit_id      (cause_id)
  );

  // A hit in the SOF cycle itself belongs to the new frame, so it survives the clear.
  always_comb begin
    frame_hit_d = frame_hit_q;
    pend_id_d   = pend_id_q;
    if (startOfFrame) begin
      frame_hit_d = pixel_hit;
      pend_id_d   = pixel_hit ? cause_id : IDW'(HIT_BORDER);
    end else if (pixel_hit && !frame_hit_q) begin
      frame_hit_d = 1'b1;
      pend_id_d   = cause_id;
    end
  end

  always_comb begin
    state_d       = state_q;
    holdoff_cnt_d = holdoff_cnt_q;
    collision_d   = 1'b0;
    hit_id_d      = hit_id_q;
    hit_valid_d   = hit_valid_q;
    unique case (state_q)
      ARMED_ST: begin
        if (startOfFrame && frame_hit_q) begin
          collision_d = 1'b1;
          hit_id_d    = pend_id_q;
          hit_valid_d = 1'b1;
          state_d     = WAIT_REC_ST;
        end
      end
      WAIT_REC_ST: begin
        if (startOfFrame && !totalCollision) begin
          if (HOLDOFF_FRAMES == 0) begin
            state_d = ARMED_ST;
          end else begin
            holdoff_cnt_d = 4'(HOLDOFF_FRAMES);
            state_d       = HOLDOFF_ST;
          end
        end
      end
      HOLDOFF_ST: begin
        if (totalCollision) begin
          holdoff_cnt_d = 4'd0;
          state_d       = WAIT_REC_ST;
        end else if (startOfFrame) begin
          if (holdoff_cnt_q <= 4'd1) begin
            holdoff_cnt_d = 4'd0;
            state_d       = ARMED_ST;
          end else begin
            holdoff_cnt_d = holdoff_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = ARMED_ST;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ARMED_ST;
      frame_hit_q   <= 1'b0;
      pend_id_q     <= '0;
      holdoff_cnt_q <= 4'd0;
      collision_q   <= 1'b0;
      hit_id_q      <= '0;
      hit_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_hit_q   <= frame_hit_d;
      pend_id_q     <= pend_id_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      collision_q   <= collision_d;
      hit_id_q      <= hit_id_d;
      hit_valid_q   <= hit_valid_d;
    end
  end

  assign collision = collision_q;
  assign hit_id    = hit_id_q;
  assign hit_valid = hit_valid_q;

`ifdef COLLISION_HIT_COUNT_EN
  logic [7:0] hit_count_q, hit_count_d;

  always_comb begin
    hit_count_d = hit_count_q;
    if (collision_d && hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) hit_count_q <= 8'd0;
    else         hit_count_q <= hit_count_d;
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_player_collision_detector.sv
// Directed bench for player_collision_detector (NUM_OBST=4, HOLDOFF_FRAMES=2).
module tb_player_collision_detector;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic       player = 1'b0;
  logic [3:0] obst = 4'b0;
  logic       border = 1'b0;
  logic       tc = 1'b0;
  logic       coll;
  logic [2:0] id;
  logic       valid;
`ifdef COLLISION_HIT_COUNT_EN
  logic [7:0] hit_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  player_collision_detector #(
    .NUM_OBST       (4),
    .HOLDOFF_FRAMES (2)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .player_dr      (player),
    .obstacle_dr    (obst),
    .border_dr      (border),
    .totalCollision (tc),
    .collision      (coll),
    .hit_id         (id),
    .hit_valid      (valid)
`ifdef COLLISION_HIT_COUNT_EN
    ,
    .hit_count      (hit_count)
`endif
  );

  typedef struct {
    logic       p;
    logic [3:0] o;
    logic       b;
    logic       s;
    logic       e_coll;
    logic [2:0] e_id;
    logic       e_val;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one pixel cycle; returns 1 time unit after the sampling edge.
  task automatic pix(input logic p, input logic [3:0] o, input logic b, input logic s,
                     input logic t);
    player = p; obst = o; border = b; sof = s; tc = t;
    @(posedge clk);
    #1;
    player = 1'b0; obst = 4'b0; border = 1'b0; sof = 1'b0;
  endtask

  task automatic add(input logic p, input logic [3:0] o, input logic b, input logic s,
                     input logic ec, input logic [2:0] eid, input logic ev);
    vec_t v;
    v.p = p; v.o = o; v.b = b; v.s = s; v.e_coll = ec; v.e_id = eid; v.e_val = ev;
    vecs.push_back(v);
  endtask

  // One SOF cycle followed by four pixels, optionally overlapping obstacle 0.
  task automatic run_frame(input string nm, input logic t, input logic ov, input logic ep,
                           input logic [2:0] eid);
    pix(1'b0, 4'b0, 1'b0, 1'b1, t);
    check({nm, " pulse"}, 32'(coll), 32'(ep));
    if (ep) check({nm, " id"}, 32'(id), 32'(eid));
    for (int k = 0; k < 4; k++) begin
      pix(ov, ov ? 4'b0001 : 4'b0000, 1'b0, 1'b0, t);
      check($sformatf("%s px%0d no pulse", nm, k), 32'(coll), 32'd0);
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset coll", 32'(coll), 32'd0);
    check("reset id", 32'(id), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    resetN = 1'b1;

    // Pending hit discarded by a mid-frame reset.
    pix(1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    pix(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    pix(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    resetN = 1'b0;
    #3;
    resetN = 1'b1;
    pix(1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    pix(1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    check("midreset no pulse", 32'(coll), 32'd0);
    pix(1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    check("midreset coll", 32'(coll), 32'd0);
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset id", 32'(id), 32'd0);

    // Obstacle 2 for five pixels -> id 3.
    add(0, 4'b0000, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 4'b0100, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 3, 1);
    add(0, 4'b0000, 0, 0, 0, 3, 1);
    add(0, 4'b0000, 0, 1, 0, 3, 1);
    add(0, 4'b0000, 0, 1, 0, 3, 1);
    add(0, 4'b0000, 0, 1, 0, 3, 1);
    // Simultaneous obstacles 1,3 and border -> id 2.
    add(1, 4'b1010, 1, 0, 0, 3, 1);
    add(0, 4'b0000, 0, 1, 1, 2, 1);
    add(0, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 1, 0, 2, 1);
    add(0, 4'b0000, 0, 1, 0, 2, 1);
    add(1, 4'b0001, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 1, 0, 2, 1);
    // Border overlap in the SOF cycle counts for the new frame.
    add(1, 4'b0000, 1, 1, 0, 2, 1);
    add(0, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      pix(vecs[i].p, vecs[i].o, vecs[i].b, vecs[i].s, 1'b0);
      check($sformatf("vec[%0d] coll", i), 32'(coll), 32'(vecs[i].e_coll));
      check($sformatf("vec[%0d] id", i), 32'(id), 32'(vecs[i].e_id));
      check($sformatf("vec[%0d] valid", i), 32'(valid), 32'(vecs[i].e_val));
    end
`ifdef COLLISION_HIT_COUNT_EN
    check("hit_count after 3 hits", 32'(hit_count), 32'd3);
`endif

    // Recovery held for three frames, then two hold-off frames, then a hit frame.
    for (int f = 0; f < 3; f++) run_frame($sformatf("rec%0d", f), 1'b1, 1'b1, 1'b0, 3'd0);
    run_frame("drop", 1'b0, 1'b1, 1'b0, 3'd0);
    run_frame("hold1", 1'b0, 1'b1, 1'b0, 3'd0);
    run_frame("hold2", 1'b0, 1'b1, 1'b0, 3'd0);
    run_frame("rearm", 1'b0, 1'b0, 1'b1, 3'd1);

    // totalCollision rising during hold-off restarts the recovery wait.
    run_frame("ho_a", 1'b0, 1'b0, 1'b0, 3'd0);
    pix(1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    check("ho tc rise", 32'(coll), 32'd0);
    run_frame("ho_b", 1'b0, 1'b0, 1'b0, 3'd0);
    run_frame("ho_c", 1'b0, 1'b1, 1'b0, 3'd0);
    run_frame("ho_d", 1'b0, 1'b1, 1'b0, 3'd0);
    run_frame("ho_e", 1'b0, 1'b0, 1'b1, 3'd1);
    check("valid sticky", 32'(valid), 32'd1);

`ifdef COLLISION_HIT_COUNT_EN
    for (int h = 0; h < 300; h++) begin
      pix(1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
      pix(1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
      pix(1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
      pix(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
      pix(1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
      pix(1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    end
    check("hit_count saturates", 32'(hit_count), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
